// File: rtl/lfsr_index_finder_if.sv
// Request/result bundle for the LFSR index finder: seed and target in, index/found/done/busy out.
// master = requester, slave = finder.
interface lfsr_index_finder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] idx;
    logic             found;
    logic             done;
    logic             busy;

    modport master (
        output start, sw_in, target,
        input  idx, found, done, busy
    );

    modport slave (
        input  start, sw_in, target,
        output idx, found, done, busy
    );
endinterface

// File: rtl/lfsr_index_finder.sv
// Purpose: recovers the sequence index of a target value by stepping an LFSR from the seed.
// Latency: index k reported k+1 cycles after acceptance, not-found after MAX_STEPS cycles.
// Backpressure: start is only sampled while idle; requests made while busy are dropped.
module lfsr_index_finder #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 'hB8,
    parameter int               MAX_STEPS = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    lfsr_index_finder_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] LAST_CNT  = WIDTH'(MAX_STEPS - 1);
    localparam logic [WIDTH-1:0] NOT_FOUND = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic             found_q, found_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] lfsr_step;

    // Same step as the forward generator, so k steps from the seed lands on index k.
    assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        found_d = found_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                // Previous result stays visible until the next request is taken.
                if (bus.start) begin
                    lfsr_d  = bus.sw_in;
                    tgt_d   = bus.target;
                    cnt_d   = '0;
                    idx_d   = '0;
                    found_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (lfsr_q == tgt_q) begin
                    idx_d   = cnt_q;
                    found_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    // Index MAX_STEPS would alias index 0, so the period is exhausted here.
                    idx_d   = NOT_FOUND;
                    found_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    lfsr_d = lfsr_step;
                    cnt_d  = cnt_q + WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.idx   = idx_q;
    assign bus.found = found_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_lfsr_index_finder.sv
// Randomised bench for lfsr_index_finder against a sequence-table reference model.
module tb_lfsr_index_finder;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    lfsr_index_finder_if #(.WIDTH(8)) bus ();

    lfsr_index_finder #(.WIDTH(8), .TAPS(8'hB8), .MAX_STEPS(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Forward generator: value at index k is the seed advanced k times.
    function automatic logic [7:0] value_at(input logic [7:0] seed, input int k);
        logic [7:0] v;
        v = seed;
        for (int i = 0; i < k; i++)
            v = {v[6:0], ^(v & 8'hB8)};
        return v;
    endfunction

    // Table lookup over one full period: first index holding the target, else not found.
    function automatic void model_index(input logic [7:0] seed, input logic [7:0] tgt,
                                        output logic [7:0] idx, output logic fnd);
        logic [7:0] seq [255];
        for (int k = 0; k < 255; k++) seq[k] = value_at(seed, k);
        idx = 8'hFF;
        fnd = 1'b0;
        for (int k = 0; k < 255; k++) begin
            if (!fnd && seq[k] == tgt) begin
                idx = 8'(k);
                fnd = 1'b1;
            end
        end
    endfunction

    task automatic run_search(input string tag, input logic [7:0] seed, input logic [7:0] tgt,
                              input logic [7:0] exp_idx, input logic exp_found, input bit disturb);
        int  n;
        int  busy_n;
        int  exp_lat;
        bit  seen;
        exp_lat = exp_found ? int'(exp_idx) + 1 : 255;
        @(negedge clk);
        bus.sw_in  = seed;
        bus.target = tgt;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.sw_in  = 8'($urandom);
        bus.target = 8'($urandom);
        n = 0;
        busy_n = 0;
        seen = 1'b0;
        while (n < 300 && !seen) begin
            if (bus.busy) busy_n++;
            @(posedge clk);
            #1;
            n++;
            if (disturb && n == 2) begin
                bus.start  = 1'b1;
                bus.target = ~tgt;
                bus.sw_in  = seed ^ 8'h5A;
            end
            if (disturb && n == 3) bus.start = 1'b0;
            seen = bus.done;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " busy_cycles"}, busy_n, exp_lat);
        check({tag, " idx"}, bus.idx, exp_idx);
        check({tag, " found"}, bus.found, exp_found);
        check({tag, " busy_at_done"}, bus.busy, 0);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, bus.done, 0);
        check({tag, " idx_held"}, bus.idx, exp_idx);
    endtask

    initial begin
        logic [7:0] seed, tgt, m_idx;
        logic       m_fnd;
        int         k;

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.sw_in  = 8'h00;
        bus.target = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset idx", bus.idx, 0);
        check("reset found", bus.found, 0);
        check("reset done", bus.done, 0);
        check("reset busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reference sequence from seed 01, with hand-derived expectations.
        run_search("idx0", 8'h01, 8'h01, 8'd0, 1'b1, 1'b0);
        run_search("idx4", 8'h01, 8'h11, 8'd4, 1'b1, 1'b0);
        run_search("idx5", 8'h01, 8'h23, 8'd5, 1'b1, 1'b0);
        run_search("idx3", 8'h01, 8'h08, 8'd3, 1'b1, 1'b0);
        run_search("unreach", 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0);
        run_search("seed0_hit", 8'h00, 8'h00, 8'd0, 1'b1, 1'b0);
        run_search("seed0_miss", 8'h00, 8'h05, 8'hFF, 1'b0, 1'b0);
        run_search("disturb", 8'h01, 8'h23, 8'd5, 1'b1, 1'b1);

        // Abort a search with reset at its third cycle.
        @(negedge clk);
        bus.sw_in  = 8'h01;
        bus.target = 8'h00;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort idx", bus.idx, 0);
        check("abort found", bus.found, 0);
        check("abort done", bus.done, 0);
        check("abort busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check("abort no_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_search("after_reset", 8'h01, 8'h11, 8'd4, 1'b1, 1'b0);

        // Round trip with the forward generator, seed 08.
        for (int s = 0; s <= 20; s++) begin
            run_search($sformatf("rt08_%0d", s), 8'h08, value_at(8'h08, s), 8'(s), 1'b1, 1'b0);
        end

        // Random nonzero seeds with random indices.
        for (int r = 0; r < 16; r++) begin
            seed = 8'($urandom_range(1, 255));
            k    = $urandom_range(0, 254);
            run_search($sformatf("rnd_%0d_s%0h_k%0d", r, seed, k), seed, value_at(seed, k),
                       8'(k), 1'b1, 1'b0);
        end

        // Random seed/target pairs (seed 0 included) against the table model.
        for (int r = 0; r < 8; r++) begin
            seed = (r == 0) ? 8'h00 : 8'($urandom);
            tgt  = 8'($urandom);
            model_index(seed, tgt, m_idx, m_fnd);
            run_search($sformatf("pair_%0d_s%0h_t%0h", r, seed, tgt), seed, tgt, m_idx, m_fnd, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
